// File: rtl/serial_tx.sv
// Master-side serial transmitter: samples the control inputs once per symbol, adds nibble parity,
// 8b10b-encodes the byte, inserts a K28.5 comma every SYM_PER_FRAME symbols, serializes MSB-first.
module serial_tx #(
  parameter int CLK_PER_BIT   = 3,
  parameter int SYM_PER_FRAME = 256
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_tx_en,
  input  logic       i_IsPro,
  input  logic       i_IsMaster,
  input  logic       i_RawPls,
  input  logic [2:0] i_Option,
  output logic       o_SerialData,
  output logic       o_tx_dis,
  output logic       o_tx_led,
  output logic       o_dbg_state
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int SW = $clog2(SYM_PER_FRAME);

  typedef enum logic {S_OFF = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state;
  logic [6:0]      r_sync1;
  logic [6:0]      r_sync2;
  logic [CW-1:0]   r_clk_cnt;
  logic [3:0]      r_bit_idx;
  logic [SW-1:0]   r_sym_cnt;
  logic [9:0]      r_shift;
  logic            r_rd;
  logic            r_sd;
  logic            r_tx_dis;
  logic            r_led;

  logic            w_en;
  logic            w_pro;
  logic            w_mas;
  logic            w_raw;
  logic [2:0]      w_opt;
  logic [7:0]      w_byte;
  logic            w_is_k;
  logic [7:0]      w_enc_data;
  logic            w_enc_rd_in;
  logic [9:0]      w_enc_sym;
  logic            w_enc_rd;
  logic            w_bit_end;
  logic            w_boundary;
  logic            w_sym_last;

  assign w_en  = r_sync2[6];
  assign w_pro = r_sync2[5];
  assign w_mas = r_sync2[4];
  assign w_raw = r_sync2[3];
  assign w_opt = r_sync2[2:0];

  // Both nibbles carry odd parity so the receiver can reject corrupted bytes.
  assign w_byte      = {w_pro, w_mas, w_raw, ~(w_pro ^ w_mas ^ w_raw), w_opt, ~(^w_opt)};
  assign w_is_k      = (r_state == S_OFF) || (r_sym_cnt == '0);
  assign w_enc_data  = w_is_k ? 8'hBC : w_byte;
  assign w_enc_rd_in = (r_state == S_RUN) && r_rd;

  assign w_bit_end  = (r_clk_cnt == CW'(CLK_PER_BIT - 1));
  assign w_boundary = w_bit_end && (r_bit_idx == 4'd0);
  assign w_sym_last = (r_sym_cnt == SW'(SYM_PER_FRAME - 1));

  encode_8b10b u_enc (
    .i_k    (w_is_k),
    .i_data (w_enc_data),
    .i_rd   (w_enc_rd_in),
    .o_sym  (w_enc_sym),
    .o_rd   (w_enc_rd)
  );

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_state   <= S_OFF;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_sym_cnt <= '0;
      r_shift   <= '0;
      r_rd      <= 1'b0;
      r_sd      <= 1'b0;
      r_tx_dis  <= 1'b1;
      r_led     <= 1'b0;
    end else begin
      r_sync1 <= {i_tx_en, i_IsPro, i_IsMaster, i_RawPls, i_Option};
      r_sync2 <= r_sync1;
      case (r_state)
        S_OFF: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          r_sym_cnt <= '0;
          r_shift   <= '0;
          r_rd      <= 1'b0;
          r_sd      <= 1'b0;
          r_tx_dis  <= 1'b1;
          r_led     <= 1'b0;
          // Entry loads the opening K28.5 at RD- in the same cycle the laser turns on.
          if (w_en) begin
            r_state   <= S_RUN;
            r_tx_dis  <= 1'b0;
            r_shift   <= w_enc_sym;
            r_sd      <= w_enc_sym[9];
            r_rd      <= w_enc_rd;
            r_sym_cnt <= SW'(1);
            r_bit_idx <= 4'd9;
          end
        end
        S_RUN: begin
          if (w_boundary && !w_en) begin
            r_state   <= S_OFF;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_sym_cnt <= '0;
            r_shift   <= '0;
            r_rd      <= 1'b0;
            r_sd      <= 1'b0;
            r_tx_dis  <= 1'b1;
            r_led     <= 1'b0;
          end else if (w_boundary) begin
            r_shift   <= w_enc_sym;
            r_sd      <= w_enc_sym[9];
            r_rd      <= w_enc_rd;
            r_clk_cnt <= '0;
            r_bit_idx <= 4'd9;
            r_sym_cnt <= w_sym_last ? '0 : r_sym_cnt + SW'(1);
            if (!w_is_k) r_led <= w_raw;
          end else if (w_bit_end) begin
            r_shift   <= {r_shift[8:0], 1'b0};
            r_sd      <= r_shift[8];
            r_clk_cnt <= '0;
            r_bit_idx <= r_bit_idx - 4'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        default: r_state <= S_OFF;
      endcase
    end
  end

  assign o_SerialData = r_sd;
  assign o_tx_dis     = r_tx_dis;
  assign o_tx_led     = r_led;
  assign o_dbg_state  = (r_state == S_RUN);

endmodule

// 8b10b encoder, symbol = {abcdei, fghj} with 'a' in bit 9. i_k selects the K28.y control
// group (the only control characters this link uses); i_rd/o_rd: 0 = RD-, 1 = RD+.
module encode_8b10b (
  input  logic       i_k,
  input  logic [7:0] i_data,
  input  logic       i_rd,
  output logic [9:0] o_sym,
  output logic       o_rd
);

  logic [4:0] w_x;
  logic [2:0] w_y;
  logic [5:0] w_6b_n;
  logic [5:0] w_6b;
  logic       w_rd6;
  logic       w_a7;
  logic [3:0] w_4b_n;
  logic [3:0] w_4b_p;
  logic [3:0] w_4b;

  always_comb begin
    w_x = i_data[4:0];
    w_y = i_data[7:5];
    w_6b_n = 6'b000000;
    // RD- column of the 5b/6b table.
    case (w_x)
      5'd0:  w_6b_n = 6'b100111;
      5'd1:  w_6b_n = 6'b011101;
      5'd2:  w_6b_n = 6'b101101;
      5'd3:  w_6b_n = 6'b110001;
      5'd4:  w_6b_n = 6'b110101;
      5'd5:  w_6b_n = 6'b101001;
      5'd6:  w_6b_n = 6'b011001;
      5'd7:  w_6b_n = 6'b111000;
      5'd8:  w_6b_n = 6'b111001;
      5'd9:  w_6b_n = 6'b100101;
      5'd10: w_6b_n = 6'b010101;
      5'd11: w_6b_n = 6'b110100;
      5'd12: w_6b_n = 6'b001101;
      5'd13: w_6b_n = 6'b101100;
      5'd14: w_6b_n = 6'b011100;
      5'd15: w_6b_n = 6'b010111;
      5'd16: w_6b_n = 6'b011011;
      5'd17: w_6b_n = 6'b100011;
      5'd18: w_6b_n = 6'b010011;
      5'd19: w_6b_n = 6'b110010;
      5'd20: w_6b_n = 6'b001011;
      5'd21: w_6b_n = 6'b101010;
      5'd22: w_6b_n = 6'b011010;
      5'd23: w_6b_n = 6'b111010;
      5'd24: w_6b_n = 6'b110011;
      5'd25: w_6b_n = 6'b100110;
      5'd26: w_6b_n = 6'b010110;
      5'd27: w_6b_n = 6'b110110;
      5'd28: w_6b_n = 6'b001110;
      5'd29: w_6b_n = 6'b101110;
      5'd30: w_6b_n = 6'b011110;
      5'd31: w_6b_n = 6'b101011;
      default: w_6b_n = 6'b000000;
    endcase
    if (i_k) w_6b_n = 6'b001111;

    // Unbalanced sub-blocks and the balanced alternates (D.07, D.x.3) invert at RD+.
    w_6b  = (i_rd && (($countones(w_6b_n) != 3) || (!i_k && (w_x == 5'd7)))) ? ~w_6b_n : w_6b_n;
    w_rd6 = ($countones(w_6b) > 3) ? 1'b1 : (($countones(w_6b) < 3) ? 1'b0 : i_rd);

    if (i_k) begin
      w_a7 = (w_y == 3'd7);
    end else begin
      w_a7 = (w_y == 3'd7) &&
             ((!w_rd6 && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) ||
              ( w_rd6 && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14))));
    end

    case (w_y)
      3'd0: w_4b_n = 4'b1011;
      3'd1: w_4b_n = 4'b1001;
      3'd2: w_4b_n = 4'b0101;
      3'd3: w_4b_n = 4'b1100;
      3'd4: w_4b_n = 4'b1101;
      3'd5: w_4b_n = 4'b1010;
      3'd6: w_4b_n = 4'b0110;
      3'd7: w_4b_n = w_a7 ? 4'b0111 : 4'b1110;
      default: w_4b_n = 4'b0000;
    endcase
    w_4b_p = (($countones(w_4b_n) != 2) || (w_y == 3'd3)) ? ~w_4b_n : w_4b_n;

    // K28.y flips even its neutral 4b codes so the comma stays unique.
    if (i_k) w_4b = w_rd6 ? w_4b_p : ~w_4b_p;
    else     w_4b = w_rd6 ? w_4b_p : w_4b_n;

    o_sym = {w_6b, w_4b};
    o_rd  = ($countones(o_sym) > 5) ? 1'b1 : (($countones(o_sym) < 5) ? 1'b0 : i_rd);
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: recovers each 30-clock symbol from the line, decodes it with a
// table-driven 8b10b decoder and compares against bytes built from the driven inputs.
module tb_serial_tx;

  logic       i_clk = 1'b0;
  logic       i_res_n;
  logic       i_tx_en;
  logic       i_IsPro;
  logic       i_IsMaster;
  logic       i_RawPls;
  logic [2:0] i_Option;
  logic       o_SerialData;
  logic       o_tx_dis;
  logic       o_tx_led;
  logic       o_dbg_state;

  serial_tx dut (
    .i_clk        (i_clk),
    .i_res_n      (i_res_n),
    .i_tx_en      (i_tx_en),
    .i_IsPro      (i_IsPro),
    .i_IsMaster   (i_IsMaster),
    .i_RawPls     (i_RawPls),
    .i_Option     (i_Option),
    .o_SerialData (o_SerialData),
    .o_tx_dis     (o_tx_dis),
    .o_tx_led     (o_tx_led),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock ----------------
  always #8 i_clk = ~i_clk;

  // ---------------- scoreboard / model state ----------------
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  bit         m_rd;
  int         m_idx;
  bit         m_led;

  logic [5:0] t6 [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                          6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                          6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                          6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                          6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                          6'b011110, 6'b101011};
  logic [3:0] t4 [8]  = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte the link should carry for the inputs currently driven.
  function automatic logic [7:0] model_byte();
    int hi = int'(i_IsPro) + int'(i_IsMaster) + int'(i_RawPls);
    int lo = int'(i_Option[2]) + int'(i_Option[1]) + int'(i_Option[0]);
    logic p1 = (hi % 2 == 0);
    logic p2 = (lo % 2 == 0);
    return {i_IsPro, i_IsMaster, i_RawPls, p1, i_Option, p2};
  endfunction

  // Receiver-side 8b10b decode with code and running-disparity checking.
  task automatic decode(input logic [9:0] sym, input bit rd_in, output logic [7:0] b,
                        output bit cerr, output bit derr, output bit rd_out);
    logic [5:0] c6 = sym[9:4];
    logic [3:0] c4 = sym[3:0];
    int x = -1;
    int y = -1;
    int n;
    bit r = rd_in;
    cerr = 0;
    derr = 0;
    for (int i = 0; i < 32; i++)
      if (c6 == t6[i] || (c6 == ~t6[i] && ($countones(t6[i]) != 3 || i == 7))) x = i;
    n = $countones(c6);
    if (n == 4)      begin if (r)  derr = 1; r = 1; end
    else if (n == 2) begin if (!r) derr = 1; r = 0; end
    else if (n == 3) begin
      if (c6 == 6'b111000 && r)  derr = 1;
      if (c6 == 6'b000111 && !r) derr = 1;
    end else cerr = 1;
    for (int j = 0; j < 8; j++)
      if (c4 == t4[j] || (c4 == ~t4[j] && ($countones(t4[j]) != 2 || j == 3))) y = j;
    if (c4 == 4'b0111 || c4 == 4'b1000) y = 7;
    n = $countones(c4);
    if (n == 3)      begin if (r)  derr = 1; r = 1; end
    else if (n == 1) begin if (!r) derr = 1; r = 0; end
    else if (n == 2) begin
      if (c4 == 4'b1100 && r)  derr = 1;
      if (c4 == 4'b0011 && !r) derr = 1;
    end else cerr = 1;
    if (x < 0 || y < 0) cerr = 1;
    b = {3'(y), 5'(x)};
    rd_out = r;
  endtask

  // ---------------- driver / monitor ----------------
  task automatic wait_run(input string tag);
    int n = 0;
    while (o_tx_dis === 1'b1 && n < 10) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_dis_latency"}, 32'(n), 32'd3);
    chk({tag, "_state_run"}, 32'(o_dbg_state), 32'd1);
    m_rd  = 0;
    m_idx = 0;
    m_led = 0;
    exp_q.delete();
  endtask

  // Called on the first sampling negedge of a symbol; returns on the first one of the next.
  task automatic rx_sym(input bit chg, input int drop_k, input bit glitch);
    logic       s [30];
    logic [9:0] sym;
    logic [7:0] b;
    bit         ok;
    bit         ce, de, nrd;
    if (m_idx != 0) begin
      exp_q.push_back(model_byte());
      m_led = i_RawPls;
    end
    chk("tx_dis_run", 32'(o_tx_dis), 32'd0);
    chk("tx_led", 32'(o_tx_led), 32'(m_led));
    for (int k = 0; k < 30; k++) begin
      s[k] = o_SerialData;
      if (chg && k == 15) begin
        i_IsPro    = 1'($urandom_range(0, 1));
        i_IsMaster = 1'($urandom_range(0, 1));
        i_RawPls   = 1'($urandom_range(0, 1));
        i_Option   = 3'($urandom_range(0, 7));
      end
      if (k == drop_k) i_tx_en = 1'b0;
      if (glitch && k == 5)  i_tx_en = 1'b0;
      if (glitch && k == 10) i_tx_en = 1'b1;
      @(negedge i_clk);
    end
    ok = 1;
    for (int j = 0; j < 10; j++) begin
      if (s[3*j] !== s[3*j+1] || s[3*j] !== s[3*j+2]) ok = 0;
      sym[9-j] = s[3*j];
    end
    chk("bit_width", 32'(ok), 32'd1);
    if (m_idx == 0) begin
      chk("k28_5", 32'(sym), m_rd ? 32'b1100000101 : 32'b0011111010);
      m_rd = ~m_rd;
    end else begin
      decode(sym, m_rd, b, ce, de, nrd);
      m_rd = nrd;
      chk("data_byte", 32'(b), 32'(exp_q.pop_front()));
      chk("code_err", 32'(ce), 32'd0);
      chk("disp_err", 32'(de), 32'd0);
    end
    m_idx = (m_idx + 1) % 256;
  endtask

  task automatic idle_check(input string tag, input int cycles);
    bit bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (o_tx_dis !== 1'b1 || o_SerialData !== 1'b0 || o_tx_led !== 1'b0) bad = 1;
      @(negedge i_clk);
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    i_res_n    = 1'b0;
    i_tx_en    = 1'b0;
    i_IsPro    = 1'b0;
    i_IsMaster = 1'b0;
    i_RawPls   = 1'b0;
    i_Option   = 3'b000;
    repeat (3) @(negedge i_clk);
    chk("rst_line", 32'(o_SerialData), 32'd0);
    chk("rst_tx_dis", 32'(o_tx_dis), 32'd1);
    chk("rst_led", 32'(o_tx_led), 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'd0);
    i_res_n = 1'b1;
    idle_check("off_idle", 1000);

    // Fixed pattern that must decode to 8'hBB.
    i_IsPro    = 1'b1;
    i_IsMaster = 1'b0;
    i_RawPls   = 1'b1;
    i_Option   = 3'b101;
    i_tx_en    = 1'b1;
    wait_run("enable");
    repeat (20) rx_sym(1'b0, -1, 1'b0);

    // Random inputs across three comma frames, with one tx_en glitch between boundaries.
    for (int n = 0; n < 780; n++) rx_sym(1'b1, -1, n == 100);

    // Drop tx_en 12 clocks into a symbol: it must finish, then the laser goes off.
    rx_sym(1'b0, 12, 1'b0);
    chk("drop_tx_dis", 32'(o_tx_dis), 32'd1);
    chk("drop_line", 32'(o_SerialData), 32'd0);
    chk("drop_state", 32'(o_dbg_state), 32'd0);
    idle_check("off_after_drop", 60);
    i_tx_en = 1'b1;
    wait_run("reenable");
    for (int n = 0; n < 300; n++) rx_sym(1'b1, -1, 1'b0);

    // Reset mid-symbol pulls the line low at once, then the block restarts from OFF.
    repeat (10) @(negedge i_clk);
    i_res_n = 1'b0;
    #1;
    chk("midrst_line", 32'(o_SerialData), 32'd0);
    chk("midrst_tx_dis", 32'(o_tx_dis), 32'd1);
    chk("midrst_led", 32'(o_tx_led), 32'd0);
    @(negedge i_clk);
    i_res_n = 1'b1;
    wait_run("after_reset");
    repeat (5) rx_sym(1'b1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
